// File: rtl/branch_tag_ctrl.sv
// Speculation tag allocator: in-order circular tag pool, out-of-order resolve, in-order retire, kill mask on mispredict/flush.
// Outputs combinational from state+inputs; issue stalls while full. Optional counters under `BRANCH_TAG_STATS_EN.
module branch_tag_ctrl #(
  parameter  int NR_TAGS = 4,
  localparam int TAG_W   = $clog2(NR_TAGS),
  localparam int CNT_W   = $clog2(NR_TAGS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               alloc_req_i,
  output logic               alloc_gnt_o,
  output logic [TAG_W-1:0]   alloc_tag_o,
  input  logic               resolve_valid_i,
  input  logic [TAG_W-1:0]   resolve_tag_i,
  input  logic               resolve_mispredict_i,
  output logic               kill_valid_o,
  output logic [NR_TAGS-1:0] kill_mask_o,
  output logic               full_o,
  output logic               empty_o,
`ifdef BRANCH_TAG_STATS_EN
  output logic [31:0]        mispredict_cnt_o,
  output logic [31:0]        stall_cnt_o,
`endif
  output logic [CNT_W-1:0]   count_o
);

  logic [TAG_W-1:0]   r_head;
  logic [TAG_W-1:0]   r_tail;
  logic [NR_TAGS-1:0] r_inflight;
  logic [NR_TAGS-1:0] r_resolved;
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_misp_req;
  logic               w_res_hit;
  logic               w_misp;
  logic               w_retire;
  logic               w_gnt;
  logic [TAG_W-1:0]   w_age_tag;
  logic [NR_TAGS-1:0] w_younger;

  logic [TAG_W-1:0]   w_head_nxt;
  logic [TAG_W-1:0]   w_tail_nxt;
  logic [NR_TAGS-1:0] w_inflight_nxt;
  logic [NR_TAGS-1:0] w_resolved_nxt;
  logic [CNT_W-1:0]   w_count_base;
  logic [CNT_W-1:0]   w_count_nxt;

  always_comb begin
    w_full     = (r_count == CNT_W'(NR_TAGS));
    w_empty    = (r_count == '0);
    w_misp_req = resolve_valid_i & resolve_mispredict_i;
    // Resolves of tags not in flight (and anything during flush) are dropped.
    w_res_hit  = resolve_valid_i & r_inflight[resolve_tag_i] & ~flush_i;
    w_misp     = w_res_hit & resolve_mispredict_i;
    w_retire   = r_inflight[r_head] & r_resolved[r_head];
    w_gnt      = alloc_req_i & ~w_full & ~flush_i & ~w_misp_req;
    w_age_tag  = resolve_tag_i - r_head;
  end

  // Age relative to head orders the in-flight window even when full (head == tail).
  always_comb begin
    w_younger = '0;
    for (int i = 0; i < NR_TAGS; i++) begin
      w_younger[i] = r_inflight[i] && ((TAG_W'(i) - r_head) > w_age_tag);
    end
  end

  always_comb begin
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    w_inflight_nxt = r_inflight;
    w_resolved_nxt = r_resolved;
    w_count_base   = r_count + CNT_W'(w_gnt);
    if (w_res_hit) begin
      w_resolved_nxt[resolve_tag_i] = 1'b1;
    end
    if (w_misp) begin
      w_inflight_nxt = w_inflight_nxt & ~w_younger;
      w_resolved_nxt = w_resolved_nxt & ~w_younger;
      w_tail_nxt     = resolve_tag_i + TAG_W'(1);
      w_count_base   = CNT_W'(w_age_tag) + CNT_W'(1);
    end
    if (w_gnt) begin
      w_inflight_nxt[r_tail] = 1'b1;
      w_resolved_nxt[r_tail] = 1'b0;
      w_tail_nxt             = r_tail + TAG_W'(1);
    end
    if (w_retire) begin
      w_inflight_nxt[r_head] = 1'b0;
      w_resolved_nxt[r_head] = 1'b0;
      w_head_nxt             = r_head + TAG_W'(1);
    end
    w_count_nxt = w_count_base - CNT_W'(w_retire);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= '0;
      r_resolved <= '0;
      r_count    <= '0;
    end else if (flush_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= '0;
      r_resolved <= '0;
      r_count    <= '0;
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_inflight <= w_inflight_nxt;
      r_resolved <= w_resolved_nxt;
      r_count    <= w_count_nxt;
    end
  end

  always_comb begin
    alloc_gnt_o  = w_gnt;
    alloc_tag_o  = r_tail;
    kill_valid_o = flush_i | w_misp;
    kill_mask_o  = flush_i ? r_inflight : (w_misp ? w_younger : '0);
    full_o       = w_full;
    empty_o      = w_empty;
    count_o      = r_count;
  end

`ifdef BRANCH_TAG_STATS_EN
  logic [31:0] r_misp_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_misp_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if (flush_i) begin
      r_misp_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_misp && (r_misp_cnt != '1)) begin
        r_misp_cnt <= r_misp_cnt + 32'd1;
      end
      if (alloc_req_i && w_full && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    mispredict_cnt_o = r_misp_cnt;
    stall_cnt_o      = r_stall_cnt;
  end
`endif

  a_resolve_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (resolve_valid_i && !flush_i) |-> r_inflight[resolve_tag_i]);

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Scoreboard bench for branch_tag_ctrl: queue-based reference model, directed scenarios then random traffic.
module tb_branch_tag_ctrl;
  localparam int N = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic       alloc_req_i = 1'b0;
  logic       alloc_gnt_o;
  logic [1:0] alloc_tag_o;
  logic       resolve_valid_i = 1'b0;
  logic [1:0] resolve_tag_i = 2'd0;
  logic       resolve_mispredict_i = 1'b0;
  logic       kill_valid_o;
  logic [3:0] kill_mask_o;
  logic       full_o;
  logic       empty_o;
  logic [2:0] count_o;
`ifdef BRANCH_TAG_STATS_EN
  logic [31:0] mispredict_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  branch_tag_ctrl #(.NR_TAGS(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_tag_o(alloc_tag_o),
    .resolve_valid_i(resolve_valid_i), .resolve_tag_i(resolve_tag_i),
    .resolve_mispredict_i(resolve_mispredict_i),
    .kill_valid_o(kill_valid_o), .kill_mask_o(kill_mask_o),
    .full_o(full_o), .empty_o(empty_o),
`ifdef BRANCH_TAG_STATS_EN
    .mispredict_cnt_o(mispredict_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .count_o(count_o)
  );

  typedef struct {
    bit          gnt;
    int          tag;
    bit          kv;
    int          mask;
    bit          full;
    bit          empty;
    int          count;
    bit [31:0]   mc;
    bit [31:0]   sc;
  } exp_t;

  exp_t      exp_q[$];
  int        n_vec = 0;
  int        n_bad = 0;
  int        cyc_no = 0;

  // Reference model: oldest-first list of in-flight tags with their resolved flags.
  int        m_tag[$];
  bit        m_res[$];
  int        m_next = 0;
  bit [31:0] m_mc = 0;
  bit [31:0] m_sc = 0;

  task automatic cyc(input bit fl, input bit rq, input bit rv, input int tg, input bit rm);
    exp_t e;
    int   pos;
    bit   misp;
    bit   retire;
    @(negedge clk_i);
    flush_i              = fl;
    alloc_req_i          = rq;
    resolve_valid_i      = rv;
    resolve_tag_i        = 2'(tg);
    resolve_mispredict_i = rm;
    cyc_no++;
    pos = -1;
    foreach (m_tag[k]) if (m_tag[k] == tg) pos = k;
    misp    = rv && rm && !fl && (pos >= 0);
    e.full  = (m_tag.size() == N);
    e.empty = (m_tag.size() == 0);
    e.count = m_tag.size();
    e.gnt   = rq && !e.full && !fl && !(rv && rm);
    e.tag   = m_next;
    e.kv    = fl || misp;
    e.mask  = 0;
    if (fl) begin
      foreach (m_tag[k]) e.mask |= (1 << m_tag[k]);
    end else if (misp) begin
      foreach (m_tag[k]) if (k > pos) e.mask |= (1 << m_tag[k]);
    end
    e.mc = m_mc;
    e.sc = m_sc;
    exp_q.push_back(e);

    retire = (m_tag.size() > 0) && m_res[0];
    if (fl) begin
      m_tag.delete();
      m_res.delete();
      m_next = 0;
      m_mc   = 0;
      m_sc   = 0;
    end else begin
      if (rq && e.full && m_sc != 32'hffff_ffff) m_sc++;
      if (misp) begin
        if (m_mc != 32'hffff_ffff) m_mc++;
        while (m_tag.size() > pos + 1) begin
          void'(m_tag.pop_back());
          void'(m_res.pop_back());
        end
        m_res[pos] = 1'b1;
        m_next = (tg + 1) % N;
      end else if (rv && pos >= 0) begin
        m_res[pos] = 1'b1;
      end
      if (e.gnt) begin
        m_tag.push_back(m_next);
        m_res.push_back(1'b0);
        m_next = (m_next + 1) % N;
      end
      if (retire) begin
        void'(m_tag.pop_front());
        void'(m_res.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
  endtask

  // Monitor: outputs are live every cycle, so each driven cycle yields one record to check.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        bad = (alloc_gnt_o !== e.gnt) || (int'(alloc_tag_o) != e.tag) ||
              (kill_valid_o !== e.kv) || (int'(kill_mask_o) != e.mask) ||
              (full_o !== e.full) || (empty_o !== e.empty) || (int'(count_o) != e.count);
`ifdef BRANCH_TAG_STATS_EN
        bad = bad || (mispredict_cnt_o !== e.mc) || (stall_cnt_o !== e.sc);
`endif
        n_vec++;
        if (bad) begin
          n_bad++;
          $display("FAIL outputs cyc %0d: got gnt=%0b tag=%0d kv=%0b mask=%b full=%0b empty=%0b cnt=%0d, want gnt=%0b tag=%0d kv=%0b mask=%b full=%0b empty=%0b cnt=%0d",
                   cyc_no, alloc_gnt_o, alloc_tag_o, kill_valid_o, kill_mask_o, full_o, empty_o, count_o,
                   e.gnt, e.tag, e.kv, 4'(e.mask), e.full, e.empty, e.count);
`ifdef BRANCH_TAG_STATS_EN
          $display("FAIL stats cyc %0d: got mc=%0d sc=%0d, want mc=%0d sc=%0d",
                   cyc_no, mispredict_cnt_o, stall_cnt_o, e.mc, e.sc);
`endif
        end
      end
    end
  end

  initial begin
    int fl, rq, rv, tg, rm;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    idle(1);                                 // reset state
    alloc_n(5);                              // tags 0..3, fifth denied
    cyc(0, 0, 1, 2, 0); cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 3, 0);
    idle(5);                                 // in-order drain to empty
    alloc_n(4);
    cyc(0, 0, 1, 1, 1);                      // kill 1100
    alloc_n(1);                              // re-grants tag 2
    cyc(1, 0, 0, 0, 0);
    alloc_n(4);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 2, 0);
    idle(3);
    alloc_n(2);                              // head=3, in flight 3,0,1
    cyc(0, 0, 1, 3, 1);                      // kill 0011, tail -> 0
    cyc(1, 0, 0, 0, 0);
    alloc_n(3);
    cyc(0, 1, 1, 2, 1);                      // grant suppressed by mispredict
    cyc(0, 1, 0, 0, 0);                      // tag 3 granted
    cyc(1, 0, 0, 0, 0);
    alloc_n(3);
    cyc(1, 0, 1, 0, 0);                      // flush beats resolve, mask 0111
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      fl = ($urandom_range(99) < 2);
      rq = ($urandom_range(99) < 60);
      rv = (m_tag.size() > 0) && ($urandom_range(99) < 45);
      tg = rv ? m_tag[$urandom_range(m_tag.size() - 1)] : int'($urandom_range(N - 1));
      rm = ($urandom_range(99) < 15);
      cyc(fl[0], rq[0], rv[0], tg, rm[0]);
    end
    idle(2);

    repeat (3) @(negedge clk_i);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d records left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
